// File: rtl/rgbw_spi_pwm_bank.sv
// Addressed SPI write-frame decoder feeding a bank of NCH duty shadow registers,
// plus NCH glitch-free PWM outputs that reload their active duty at period wrap.
module rgbw_spi_pwm_bank #(
  parameter int NCH   = 4,
  parameter int DW    = 8,
  parameter int PRESC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sck,
  input  logic           cs_n,
  input  logic           mosi,
  output logic [NCH-1:0] pwm_out,
  output logic           rx_valid,
  output logic [6:0]     rx_addr,
  output logic [DW-1:0]  rx_data,
  output logic           frame_err
);

  localparam int FL  = 8 + DW;
  localparam int BCW = $clog2(FL + 1);
  localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [BCW-1:0] FL_CNT  = BCW'(FL);
  localparam logic [PW-1:0]  PRE_MAX = PW'(PRESC - 1);
  localparam logic [DW-1:0]  CNT_MAX = {{(DW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2,
    S_HOLD  = 2'd3
  } spi_state_e;

  // Synchroniser bit order is {cs_n, sck, mosi}; cs_n idles high.
  logic [2:0]            meta_q, meta_d;
  logic [2:0]            sync_q, sync_d;
  logic                  sck_prev_q, sck_prev_d;
  spi_state_e            state_q, state_d;
  logic [BCW-1:0]        bitcnt_q, bitcnt_d;
  logic [FL-1:0]         shreg_q, shreg_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [6:0]            rx_addr_q, rx_addr_d;
  logic [DW-1:0]         rx_data_q, rx_data_d;
  logic [NCH-1:0][DW-1:0] shadow_q, shadow_d;
  logic [NCH-1:0][DW-1:0] active_q, active_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic                  loaded_q, loaded_d;
  logic [NCH-1:0]        pwm_q, pwm_d;

  logic                  cs_sync_s;
  logic                  sck_rise_s;
  logic                  mosi_sync_s;
  logic                  cmd_wr_s;
  logic [6:0]            cmd_addr_s;
  logic [DW-1:0]         cmd_data_s;
  logic                  tick_s;

  assign cs_sync_s   = sync_q[2];
  assign sck_rise_s  = sync_q[1] & ~sck_prev_q;
  assign mosi_sync_s = sync_q[0];
  assign cmd_wr_s    = shreg_q[FL-1];
  assign cmd_addr_s  = shreg_q[FL-2:DW];
  assign cmd_data_s  = shreg_q[DW-1:0];

  // Input synchronisers, SPI frame FSM and shadow-register write decode.
  always_comb begin
    meta_d      = {cs_n, sck, mosi};
    sync_d      = meta_q;
    sck_prev_d  = sync_q[1];
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    frame_err_d = frame_err_q;
    rx_valid_d  = 1'b0;
    rx_addr_d   = rx_addr_q;
    rx_data_d   = rx_data_q;
    shadow_d    = shadow_q;

    case (state_q)
      S_IDLE: begin
        bitcnt_d = '0;
        if (!cs_sync_s) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cs_sync_s) begin
          state_d = S_IDLE;
          // A bare cs_n pulse without any clocked bits is not a framing error.
          if (bitcnt_q != '0) begin
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = frame_err_q;
          end
        end else if (sck_rise_s) begin
          shreg_d  = {shreg_q[FL-2:0], mosi_sync_s};
          bitcnt_d = bitcnt_q + BCW'(1);
          if (bitcnt_d == FL_CNT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_HOLD;
        if (cmd_wr_s) begin
          rx_valid_d = 1'b1;
          rx_addr_d  = cmd_addr_s;
          rx_data_d  = cmd_data_s;
          if (cmd_addr_s == 7'h7F) begin
            frame_err_d = 1'b0;
          end else begin
            frame_err_d = frame_err_q;
          end
          for (int i = 0; i < NCH; i++) begin
            if ({1'b0, cmd_addr_s} == 8'(i)) begin
              shadow_d[i] = cmd_data_s;
            end else begin
              shadow_d[i] = shadow_q[i];
            end
          end
        end else begin
          rx_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (sck_rise_s) begin
          frame_err_d = 1'b1;
        end else begin
          frame_err_d = frame_err_q;
        end
        if (cs_sync_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Prescaler, period counter, period-boundary duty reload and PWM compare.
  always_comb begin
    tick_s   = (pre_q == PRE_MAX);
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    loaded_d = loaded_q;

    if (tick_s) begin
      pre_d = '0;
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
      // Reload at wrap and once on the very first tick so reset state is defined.
      if ((cnt_q == CNT_MAX) || !loaded_q) begin
        active_d = shadow_q;
        loaded_d = 1'b1;
      end else begin
        active_d = active_q;
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end

    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = (cnt_q < active_q[i]);
    end
  end

  // State register for every flop in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= 3'b100;
      sync_q      <= 3'b100;
      sck_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_addr_q   <= 7'h00;
      rx_data_q   <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      loaded_q    <= 1'b0;
      pwm_q       <= '0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      rx_valid_q  <= rx_valid_d;
      rx_addr_q   <= rx_addr_d;
      rx_data_q   <= rx_data_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign rx_valid  = rx_valid_q;
  assign rx_addr   = rx_addr_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rgbw_spi_pwm_bank.sv
// Directed bench for rgbw_spi_pwm_bank: expected frames are queued at stimulus time
// and a forked monitor pops and compares them on every rx_valid pulse.
module tb_rgbw_spi_pwm_bank;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int PRESC = 1;

  logic           clk;
  logic           rst_n;
  logic           sck;
  logic           cs_n;
  logic           mosi;
  logic [NCH-1:0] pwm_out;
  logic           rx_valid;
  logic [6:0]     rx_addr;
  logic [DW-1:0]  rx_data;
  logic           frame_err;

  typedef struct {
    logic [6:0]    addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   pulses;
  int   cyc;
  int   hi_cnt[NCH];
  int   p1;
  int   p2;

  rgbw_spi_pwm_bank #(.NCH(NCH), .DW(DW), .PRESC(PRESC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (sck),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .pwm_out  (pwm_out),
    .rx_valid (rx_valid),
    .rx_addr  (rx_addr),
    .rx_data  (rx_data),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number since reset release: edge k after release sets cyc = k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_valid_unexpected: got pulse addr %0h data %0h, required no pulse",
                   rx_addr, rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_addr", 32'(rx_addr), 32'(e.addr));
          check("rx_data", 32'(rx_data), 32'(e.data));
        end
      end
    end
  endtask

  // Sends the low n bits of w MSB first, sck toggling every 4 clk on falling clk edges.
  task automatic send_bits(input logic [31:0] w, input int n, input bit end_cs);
    cs_n = 1'b0;
    for (int j = n - 1; j >= 0; j--) begin
      mosi = w[j];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    if (end_cs) begin
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data, input bit expect_valid);
    exp_t e;
    if (expect_valid) begin
      e.addr = cmd[6:0];
      e.data = data;
      exp_q.push_back(e);
    end
    send_bits({16'h0000, cmd, data}, 16, 1'b1);
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < NCH; c++) if (pwm_out[c] === 1'b1) hi_cnt[c]++;
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    rst_n  = 1'b0;
    sck    = 1'b0;
    cs_n   = 1'b1;
    mosi   = 1'b0;
    fork
      monitor();
    join_none

    // Reset state, then 600 idle cycles.
    repeat (5) @(negedge clk);
    check("reset_pwm_out", 32'(pwm_out), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_rx_addr", 32'(rx_addr), 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    rst_n = 1'b1;
    measure(600);
    for (int c = 0; c < NCH; c++) check("idle_pwm_high_count", 32'(hi_cnt[c]), 32'd0);
    check("idle_frame_err", 32'(frame_err), 32'h0);

    // Channel 1 duty 0x40.
    send_frame(8'h81, 8'h40, 1'b1);
    repeat (300) @(negedge clk);
    check("ch1_write_pulses", 32'(pulses), 32'd1);
    measure(255);
    check("ch1_duty64", 32'(hi_cnt[1]), 32'd64);
    check("ch0_low", 32'(hi_cnt[0]), 32'd0);
    check("ch2_low", 32'(hi_cnt[2]), 32'd0);
    check("ch3_low", 32'(hi_cnt[3]), 32'd0);

    // Duty extremes over two full periods.
    send_frame(8'h80, 8'h00, 1'b1);
    send_frame(8'h83, 8'hFF, 1'b1);
    repeat (300) @(negedge clk);
    measure(510);
    check("ch0_duty0_never_high", 32'(hi_cnt[0]), 32'd0);
    check("ch3_dutymax_always_high", 32'(hi_cnt[3]), 32'd510);
    check("ch1_two_periods", 32'(hi_cnt[1]), 32'd128);

    // Aborted frame after 10 bits of 0x82,0x33.
    send_bits(32'h8233 >> 6, 10, 1'b1);
    check("abort_frame_err", 32'(frame_err), 32'h1);
    repeat (300) @(negedge clk);
    measure(255);
    check("abort_ch2_unchanged", 32'(hi_cnt[2]), 32'd0);
    send_frame(8'hFF, 8'h00, 1'b1);
    check("clear_frame_err", 32'(frame_err), 32'h0);

    // 18 sck edges: frame accepted, extra edges flagged.
    exp_q.push_back('{addr: 7'h02, data: 8'h33});
    send_bits({14'h0, 16'h8233, 2'b11}, 18, 1'b1);
    check("extra_edges_frame_err", 32'(frame_err), 32'h1);
    repeat (300) @(negedge clk);
    measure(255);
    check("extra_edges_ch2_duty51", 32'(hi_cnt[2]), 32'd51);
    send_frame(8'hFF, 8'h00, 1'b1);
    check("clear_frame_err_2", 32'(frame_err), 32'h0);

    // Write-enable clear: no pulse, no duty change.
    send_frame(8'h02, 8'h55, 1'b0);
    repeat (300) @(negedge clk);
    measure(255);
    check("noop_ch2_unchanged", 32'(hi_cnt[2]), 32'd51);

    // Address beyond the bank.
    send_frame(8'h85, 8'h12, 1'b1);
    repeat (300) @(negedge clk);
    measure(255);
    check("oob_ch0", 32'(hi_cnt[0]), 32'd0);
    check("oob_ch1", 32'(hi_cnt[1]), 32'd64);
    check("oob_ch2", 32'(hi_cnt[2]), 32'd51);
    check("oob_ch3", 32'(hi_cnt[3]), 32'd255);

    // Reset in the middle of a frame.
    send_bits(32'h8233 >> 11, 5, 1'b1);
    check("pre_reset_frame_err", 32'(frame_err), 32'h1);
    send_bits(32'h81 >> 2, 6, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_pwm_out", 32'(pwm_out), 32'h0);
    check("midreset_frame_err", 32'(frame_err), 32'h0);
    check("midreset_rx_addr", 32'(rx_addr), 32'h0);
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    cs_n = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Wraps land on edges 255, 510, 765. The second write lands on edge 510
    // (last sck rise on negedge 382+124, synchronised 2 clk, shift, then write).
    while (cyc < 10) @(negedge clk);
    send_frame(8'h80, 8'h20, 1'b1);
    fork
      begin
        while (cyc < 382) @(negedge clk);
        send_frame(8'h80, 8'h60, 1'b1);
      end
      begin
        while (cyc < 511) @(negedge clk);
        measure(255);
        p1 = hi_cnt[0];
        measure(255);
        p2 = hi_cnt[0];
      end
    join
    check("coincide_old_duty", 32'(p1), 32'd32);
    check("coincide_new_duty", 32'(p2), 32'd96);

    repeat (20) @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
